mem_arbiter_rr: RTL and testbench

- Parametrised multi-port memory arbiter; next generation of the two-port memory controller.
- Sits between N pipeline requesters and a single downstream memory port. Defaults: port 0 = data/stage 4, port 1 = instruction fetch.
- Arbitrates by round-robin or fixed priority.
- Issues one transaction at a time over a valid/ready memory handshake and returns the read data or write acknowledge to the winning port, with a response-timeout error.

---
 rtl/mem_arbiter_rr.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: round-robin or fixed-priority grant, one transaction in flight,
// valid/ready downstream handshake and a read-response timeout.
module mem_arbiter_rr #(
    parameter int N_PORTS = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_PORTS-1:0]      i_req_valid,
    input  logic [N_PORTS*AW-1:0]   i_req_addr,
    input  logic [N_PORTS*DW-1:0]   i_req_wdata,
    input  logic [N_PORTS-1:0]      i_req_we,
    input  logic [N_PORTS*DW/8-1:0] i_req_be,
    output logic [N_PORTS-1:0]      o_req_ready,
    output logic [N_PORTS-1:0]      o_rsp_valid,
    output logic [DW-1:0]           o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_mem_valid,
    output logic [AW-1:0]           o_mem_addr,
    output logic [DW-1:0]           o_mem_wdata,
    output logic                    o_mem_we,
    output logic [DW/8-1:0]         o_mem_be,
    input  logic                    i_mem_ready,
    input  logic                    i_mem_rvalid,
    input  logic [DW-1:0]           i_mem_rdata
);

    localparam int BW = DW / 8;
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_owner;
    logic [CW-1:0]        r_cnt;
    logic                 r_mem_valid;
    logic [AW-1:0]        r_mem_addr;
    logic [DW-1:0]        r_mem_wdata;
    logic                 r_mem_we;
    logic [BW-1:0]        r_mem_be;
    logic [N_PORTS-1:0]   r_rsp_valid;
    logic [DW-1:0]        r_rsp_rdata;
    logic                 r_rsp_err;

    logic                 w_found;
    logic [PW-1:0]        w_gnt;
    logic [PW-1:0]        w_sel;
    int                   w_idx;
    logic [N_PORTS-1:0]   w_ready;

    // Winner search: in RR mode start just after the last grant and wrap; otherwise from port 0.
    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_idx = (RR_MODE != 0) ? ((int'(r_ptr) + 1 + i) % N_PORTS) : i;
            w_sel = PW'(w_idx);
            if (!w_found && i_req_valid[w_sel]) begin
                w_found = 1'b1;
                w_gnt   = w_sel;
            end
        end
    end

    // Acceptance is combinational so the requester sees ready in the same cycle it is chosen.
    always_comb begin
        w_ready = '0;
        if (!i_rst && r_state == S_IDLE && w_found) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= PW'(N_PORTS - 1);
            r_owner     <= '0;
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner     <= w_gnt;
                        r_mem_addr  <= i_req_addr[int'(w_gnt)*AW +: AW];
                        r_mem_wdata <= i_req_wdata[int'(w_gnt)*DW +: DW];
                        r_mem_we    <= i_req_we[w_gnt];
                        r_mem_be    <= i_req_be[int'(w_gnt)*BW +: BW];
                        r_mem_valid <= 1'b1;
                        if (RR_MODE != 0) begin
                            r_ptr <= w_gnt;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_cnt       <= '0;
                        if (r_mem_we) begin
                            r_rsp_valid[r_owner] <= 1'b1;
                            r_state              <= S_RESP;
                        end else begin
                            r_state <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Data arriving on the limit cycle still counts as a good read.
                    if (i_mem_rvalid) begin
                        r_rsp_rdata          <= i_mem_rdata;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_state              <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_rdata          <= '0;
                        r_rsp_err            <= 1'b1;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_state              <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = w_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance share all stimulus;
// a per-cycle vector table plus directed timeout, stall and mid-read reset sequences.
module tb_mem_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_we    = '0;
    logic [7:0]  req_be    = '0;
    logic        mem_ready  = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = '0;

    logic [1:0]  rr_ready, rr_rsp_valid, fp_ready, fp_rsp_valid;
    logic [31:0] rr_rdata, rr_mem_addr, rr_mem_wdata, fp_rdata, fp_mem_addr, fp_mem_wdata;
    logic        rr_err, rr_mem_valid, rr_mem_we, fp_err, fp_mem_valid, fp_mem_we;
    logic [3:0]  rr_mem_be, fp_mem_be;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.N_PORTS(2), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(8)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_we(req_we), .i_req_be(req_be),
        .o_req_ready(rr_ready), .o_rsp_valid(rr_rsp_valid), .o_rsp_rdata(rr_rdata),
        .o_rsp_err(rr_err), .o_mem_valid(rr_mem_valid), .o_mem_addr(rr_mem_addr),
        .o_mem_wdata(rr_mem_wdata), .o_mem_we(rr_mem_we), .o_mem_be(rr_mem_be),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    mem_arbiter_rr #(.N_PORTS(2), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(8)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_we(req_we), .i_req_be(req_be),
        .o_req_ready(fp_ready), .o_rsp_valid(fp_rsp_valid), .o_rsp_rdata(fp_rdata),
        .o_rsp_err(fp_err), .o_mem_valid(fp_mem_valid), .o_mem_addr(fp_mem_addr),
        .o_mem_wdata(fp_mem_wdata), .o_mem_we(fp_mem_we), .o_mem_be(fp_mem_be),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        mem_ready;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic [1:0]  e_rdy_rr;
        logic [1:0]  e_rdy_fp;
        logic        e_mv;
        logic [31:0] e_addr_rr;
        logic [31:0] e_addr_fp;
        logic        e_we;
        logic [1:0]  e_rsp_rr;
        logic [1:0]  e_rsp_fp;
        logic        chk_data;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rr_ctrl"}, 64'({rr_ready, rr_rsp_valid, rr_err, rr_mem_valid, rr_mem_we, rr_mem_be, rr_mem_wdata}), 64'h0);
        check({tag, "_rr_data"}, 64'({rr_rdata, rr_mem_addr}), 64'h0);
        check({tag, "_fp_ctrl"}, 64'({fp_ready, fp_rsp_valid, fp_err, fp_mem_valid, fp_mem_we, fp_mem_be, fp_mem_wdata}), 64'h0);
        check({tag, "_fp_data"}, 64'({fp_rdata, fp_mem_addr}), 64'h0);
    endtask

    initial begin
        int n;

        // Single read on port 1, then both ports streaming zero-wait writes.
        vecs[0]  = '{2'b10, 2'b00, 32'h0,  32'h100, 1'b0, 1'b0, 32'h0,        2'b10, 2'b10, 1'b0, 32'h0,   32'h0,   1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{2'b00, 2'b00, 32'h0,  32'h100, 1'b1, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 32'h100, 32'h100, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
        vecs[2]  = '{2'b00, 2'b00, 32'h0,  32'h0,   1'b0, 1'b1, 32'hDEADBEEF, 2'b00, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{2'b00, 2'b00, 32'h0,  32'h0,   1'b0, 1'b1, 32'h12345678, 2'b00, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 2'b10, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{2'b00, 2'b00, 32'h0,  32'h0,   1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 2'b00, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0};
        for (int t = 0; t < 4; t++) begin
            vecs[5 + 3*t] = '{2'b11, 2'b11, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0,
                              (t % 2 == 0) ? 2'b01 : 2'b10, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
            vecs[6 + 3*t] = '{2'b11, 2'b11, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0,
                              2'b00, 2'b00, 1'b1, (t % 2 == 0) ? 32'h40 : 32'h80, 32'h40, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
            vecs[7 + 3*t] = '{2'b11, 2'b11, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0,
                              2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, (t % 2 == 0) ? 2'b01 : 2'b10, 2'b01, 1'b0, 32'h0, 1'b0};
        end
        vecs[17] = '{2'b00, 2'b00, 32'h0,  32'h0,   1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};

        #2;
        check_zero("reset");
        tick();
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tick();
            req_valid  = vecs[i].valid;
            req_we     = vecs[i].we;
            req_addr   = {vecs[i].addr1, vecs[i].addr0};
            req_wdata  = {32'hB1B1B1B1, 32'hA0A0A0A0};
            req_be     = 8'hFF;
            mem_ready  = vecs[i].mem_ready;
            mem_rvalid = vecs[i].mem_rvalid;
            mem_rdata  = vecs[i].mem_rdata;
            #3;
            check($sformatf("v%0d_ready_rr", i), 64'(rr_ready), 64'(vecs[i].e_rdy_rr));
            check($sformatf("v%0d_ready_fp", i), 64'(fp_ready), 64'(vecs[i].e_rdy_fp));
            check($sformatf("v%0d_mem_valid", i), 64'(rr_mem_valid), 64'(vecs[i].e_mv));
            check($sformatf("v%0d_rsp_rr", i), 64'(rr_rsp_valid), 64'(vecs[i].e_rsp_rr));
            check($sformatf("v%0d_rsp_fp", i), 64'(fp_rsp_valid), 64'(vecs[i].e_rsp_fp));
            if (vecs[i].e_mv) begin
                check($sformatf("v%0d_addr_rr", i), 64'(rr_mem_addr), 64'(vecs[i].e_addr_rr));
                check($sformatf("v%0d_addr_fp", i), 64'(fp_mem_addr), 64'(vecs[i].e_addr_fp));
                check($sformatf("v%0d_we", i), 64'(rr_mem_we), 64'(vecs[i].e_we));
            end
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_rdata", i), 64'(rr_rdata), 64'(vecs[i].e_rdata));
                check($sformatf("v%0d_err", i), 64'(rr_err), 64'(vecs[i].e_err));
            end
        end

        // Read on port 0 that never gets data: error response 8 cycles into WAIT_RD.
        tick();
        req_valid = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'h200}; mem_ready = 1'b0; mem_rvalid = 1'b0;
        #3;
        check("to_grant", 64'(rr_ready), 64'h1);
        tick();
        req_valid = 2'b00; mem_ready = 1'b1;
        #3;
        check("to_issue", 64'({rr_mem_valid, rr_mem_we, rr_mem_addr}), 64'({1'b1, 1'b0, 32'h200}));
        tick();
        mem_ready = 1'b0;
        n = 0;
        #3;
        while (rr_rsp_valid == 2'b00 && n < 20) begin
            tick();
            #3;
            n++;
        end
        check("to_latency", 64'(n), 64'd8);
        check("to_rsp", 64'({rr_rsp_valid, rr_err, rr_rdata}), 64'({2'b01, 1'b1, 32'h0}));
        tick();
        req_valid = 2'b10; req_we = 2'b10; req_addr = {32'h300, 32'h0}; mem_ready = 1'b1;
        #3;
        check("to_after_idle", 64'({rr_rsp_valid, rr_err}), 64'h0);
        check("to_next_grant", 64'(rr_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        #3;
        check("to_next_issue", 64'({rr_mem_valid, rr_mem_we, rr_mem_addr}), 64'({1'b1, 1'b1, 32'h300}));
        tick();
        mem_ready = 1'b0;
        #3;
        check("to_next_ack", 64'({rr_rsp_valid, rr_err}), 64'({2'b10, 1'b0}));

        // Write stalled by mem_ready low for 5 cycles; requester payload changes after acceptance.
        tick();
        req_valid = 2'b01; req_we = 2'b01; req_addr = {32'h0, 32'h400};
        req_wdata = {32'h0, 32'hA5A55A5A}; req_be = 8'h03;
        #3;
        check("st_grant", 64'(rr_ready), 64'h1);
        tick();
        req_valid = 2'b00; req_addr = 64'hFFFF_FFFF_FFFF_FFFF; req_wdata = 64'h1111_1111_1111_1111; req_be = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            mem_ready = (k == 5);
            #3;
            check($sformatf("st_ctrl_%0d", k), 64'({rr_mem_valid, rr_mem_we, rr_mem_be, rr_rsp_valid}), 64'({1'b1, 1'b1, 4'b0011, 2'b00}));
            check($sformatf("st_data_%0d", k), 64'({rr_mem_addr, rr_mem_wdata}), {32'h400, 32'hA5A55A5A});
            tick();
        end
        mem_ready = 1'b0;
        #3;
        check("st_ack", 64'({rr_rsp_valid, rr_err, rr_mem_valid}), 64'({2'b01, 1'b0, 1'b0}));

        // Reset asserted while a port-0 read waits; afterwards port 0 must win first again.
        tick();
        req_valid = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'h500}; req_be = 8'h0F;
        #3;
        check("rs_grant", 64'(rr_ready), 64'h1);
        tick();
        req_valid = 2'b00; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        #1;
        check_zero("rs_mid");
        for (int k = 0; k < 3; k++) begin
            tick();
            #3;
            check($sformatf("rs_hold_%0d", k), 64'({rr_rsp_valid, fp_rsp_valid, rr_mem_valid}), 64'h0);
        end
        tick();
        rst = 1'b0; mem_rvalid = 1'b0; req_valid = 2'b11; req_we = 2'b11; mem_ready = 1'b1;
        #3;
        check("rs_first_rr", 64'(rr_ready), 64'h1);
        check("rs_first_fp", 64'(fp_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        tick();
        #3;
        check("rs_ack", 64'(rr_rsp_valid), 64'h1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
